// File: rtl/lsu.sv
// Load/store unit: bridges the core's data port to a single-outstanding valid/ready bus,
// formatting store lanes and byte enables and aligning/extending load data.
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_req,
    input  logic        dmem_wr,
    input  logic [1:0]  dmem_size,
    input  logic        dmem_zero_ex,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        misalign_err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    state_t      state;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        zero_ex_q;
    logic        err_q;

    logic        misaligned;
    logic [3:0]  be_fmt;
    logic [31:0] wdata_fmt;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    // Request formatting from the live core inputs; only consumed in IDLE.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        misaligned = 1'b0;
        be_fmt     = 4'b1111;
        wdata_fmt  = wdata;
        case (dmem_size)
            2'd0: begin
                be_fmt    = 4'b0001 << addr[1:0];
                wdata_fmt = {4{wdata[7:0]}};
            end
            2'd1: begin
                misaligned = addr[0];
                be_fmt     = 4'b0011 << {addr[1], 1'b0};
                wdata_fmt  = {2{wdata[15:0]}};
            end
            default: misaligned = |addr[1:0];
        endcase
    end

    assign shifted = bus_rdata >> {off_q, 3'b000};

    always_comb begin
        load_ext = bus_rdata;
        case (size_q)
            2'd0:    load_ext = {{24{~zero_ex_q & shifted[7]}}, shifted[7:0]};
            2'd1:    load_ext = {{16{~zero_ex_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = bus_rdata;
        endcase
    end

    assign stall        = dmem_req && (state != DONE);
    assign misalign_err = err_q;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            rdata     <= '0;
            err_q     <= 1'b0;
            size_q    <= '0;
            off_q     <= '0;
            zero_ex_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dmem_req) begin
                        if (misaligned) begin
                            err_q <= 1'b1;
                            rdata <= '0;
                            state <= DONE;
                        end else begin
                            bus_valid <= 1'b1;
                            bus_we    <= dmem_wr;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= be_fmt;
                            bus_wdata <= wdata_fmt;
                            size_q    <= dmem_size;
                            off_q     <= addr[1:0];
                            zero_ex_q <= dmem_zero_ex;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    // Payload registers are untouched here, so they stay stable under backpressure.
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        state     <= bus_we ? DONE : WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (bus_rvalid) begin
                        rdata <= load_ext;
                        state <= DONE;
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized accesses
// compared against an arithmetic reference model of alignment and extension rules.
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        dmem_req;
    logic        dmem_wr;
    logic [1:0]  dmem_size;
    logic        dmem_zero_ex;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        misalign_err;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] model_rdata = '0;

    always #5 clk = ~clk;

    lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmem_req     (dmem_req),
        .dmem_wr      (dmem_wr),
        .dmem_size    (dmem_size),
        .dmem_zero_ex (dmem_zero_ex),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .rdata        (rdata),
        .misalign_err (misalign_err),
        .bus_valid    (bus_valid),
        .bus_ready    (bus_ready),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_rvalid   (bus_rvalid),
        .bus_rdata    (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic int unsigned access_bytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic model_misaligned(input logic [1:0] size, input logic [31:0] a);
        return (a % access_bytes(size)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] a);
        logic [3:0]  m;
        int unsigned first;
        first = a % 4;
        m = '0;
        for (int i = 0; i < 4; i++)
            if (i >= first && i < first + access_bytes(size)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] model_bus_wdata(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'd0) return (wd % 256) * 32'h0101_0101;
        if (size == 2'd1) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic zext,
                                               input logic [31:0] a, input logic [31:0] word);
        logic [31:0] v;
        v = word / (32'd1 << (8 * (a % 4)));
        if (size == 2'd0) begin
            v = v % 256;
            if (!zext && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = v % 65536;
            if (!zext && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    // One complete core transaction, checked cycle by cycle against the model.
    task automatic access(input logic wr, input logic [1:0] size, input logic zext,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int rdy_dly, input int rv_dly, input logic [31:0] rword);
        logic        mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_addr;
        mis      = model_misaligned(size, a);
        exp_be   = model_be(size, a);
        exp_wd   = model_bus_wdata(size, wd);
        exp_addr = a - (a % 4);

        dmem_req = 1'b1; dmem_wr = wr; dmem_size = size; dmem_zero_ex = zext;
        addr = a; wdata = wd;
        #1;
        check("idle_stall", stall, 1);
        check("idle_bus_valid", bus_valid, 0);
        @(posedge clk); #1;
        // Core inputs change after capture; the unit must not resample them.
        dmem_wr = $urandom; dmem_size = $urandom; dmem_zero_ex = $urandom;
        addr = $urandom; wdata = $urandom;

        if (mis) begin
            model_rdata = '0;
            check("mis_stall", stall, 0);
            check("mis_err", misalign_err, 1);
            check("mis_rdata", rdata, model_rdata);
            check("mis_bus_valid", bus_valid, 0);
        end else begin
            for (int i = 0; i <= rdy_dly; i++) begin
                check("req_valid", bus_valid, 1);
                check("req_addr", bus_addr, exp_addr);
                check("req_be", bus_be, exp_be);
                check("req_we", bus_we, wr);
                if (wr) check("req_wdata", bus_wdata, exp_wd);
                check("req_stall", stall, 1);
                bus_ready  = (i == rdy_dly);
                bus_rvalid = $urandom_range(0, 1);
                bus_rdata  = $urandom;
                @(posedge clk); #1;
                bus_ready  = 1'b0;
                bus_rvalid = 1'b0;
            end
            if (!wr) begin
                for (int i = 0; i <= rv_dly; i++) begin
                    check("wait_valid", bus_valid, 0);
                    check("wait_stall", stall, 1);
                    bus_rvalid = (i == rv_dly);
                    bus_rdata  = (i == rv_dly) ? rword : $urandom;
                    @(posedge clk); #1;
                    bus_rvalid = 1'b0;
                end
                model_rdata = model_load(size, zext, a, rword);
            end
            check("done_stall", stall, 0);
            check("done_valid", bus_valid, 0);
            check("done_err", misalign_err, 0);
            check("done_rdata", rdata, model_rdata);
        end
        dmem_req = 1'b0;
        @(posedge clk); #1;
        check("after_err", misalign_err, 0);
        check("after_rdata", rdata, model_rdata);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; dmem_req = 1'b0; dmem_wr = 1'b0; dmem_size = '0; dmem_zero_ex = 1'b0;
        addr = '0; wdata = '0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        #12;
        check("rst_valid", bus_valid, 0);
        check("rst_we", bus_we, 0);
        check("rst_be", bus_be, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err", misalign_err, 0);
        check("rst_stall", stall, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Store byte at 0x1003.
        access(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00A5, 0, 0, '0);
        // Signed half load at 0x2002.
        access(1'b0, 2'd1, 1'b0, 32'h0000_2002, '0, 0, 0, 32'h80FF_1234);
        check("ld_half_signed", rdata, 32'hFFFF_80FF);
        // Unsigned byte load at 0x2001.
        access(1'b0, 2'd0, 1'b1, 32'h0000_2001, '0, 0, 0, 32'h0000_F000);
        check("ld_byte_unsigned", rdata, 32'h0000_00F0);
        // Misaligned word load.
        access(1'b0, 2'd2, 1'b0, 32'h0000_3002, '0, 0, 0, '0);
        check("mis_word_rdata", rdata, 32'h0);
        // Reserved size behaves as word, with read wait states.
        access(1'b0, 2'd3, 1'b0, 32'h0000_3004, '0, 1, 3, 32'hCAFE_F00D);
        // Store under 5 cycles of backpressure; rdata must be held.
        access(1'b1, 2'd2, 1'b0, 32'h0000_4000, 32'hDEAD_BEEF, 5, 0, '0);
        check("store_keeps_rdata", rdata, 32'hCAFE_F00D);

        // Reset in WAIT_R abandons the load; a late rvalid in IDLE is ignored.
        dmem_req = 1'b1; dmem_wr = 1'b0; dmem_size = 2'd2; dmem_zero_ex = 1'b0; addr = 32'h0000_5004;
        @(posedge clk); #1;
        check("abort_req_valid", bus_valid, 1);
        bus_ready = 1'b1;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        check("abort_wait_valid", bus_valid, 0);
        rst_n = 1'b0;
        #1;
        check("abort_rdata", rdata, 0);
        check("abort_addr", bus_addr, 0);
        check("abort_be", bus_be, 0);
        check("abort_err", misalign_err, 0);
        model_rdata = '0;
        dmem_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        check("late_rvalid_rdata", rdata, 0);
        check("late_rvalid_err", misalign_err, 0);
        check("late_rvalid_valid", bus_valid, 0);
        @(posedge clk); #1;
        check("late_rvalid_rdata2", rdata, 0);
        access(1'b0, 2'd1, 1'b1, 32'h0000_6006, '0, 0, 0, 32'hBEEF_0000);

        for (int n = 0; n < 60; n++) begin
            access($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
                   $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
